// File: rtl/approx_mul_pipe.sv
// -----------------------------------------------------------------------------
// approx_mul_pipe
//
// Three-stage pipelined unsigned multiplier that computes an exact product and
// a row/column-truncated approximate product for every operand pair. It returns
// the product selected by 'mode', the per-transaction error (exact - approx),
// and keeps running saturating error statistics over approximate transactions.
//
// Approximation: the low L multiplier rows (x[L-1:0]) keep only the partial
// product bits whose column i+j >= T. The high rows x[N-1:L] are always exact.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block accepts operands (equals the pipeline advance enable)
//   x, y       N-bit unsigned multiplier / multiplicand
//   mode       0 = exact result, 1 = approximate result
//   out_valid  result valid
//   out_ready  sink accepts result
//   z          selected 2N-bit product
//   err        exact minus approximate for this transaction
//   stat_clr   clear the statistics on the next edge (wins over a handshake)
//   err_sum    saturating sum of err over accepted mode=1 results
//   txn_cnt    saturating count of accepted mode=1 results
// -----------------------------------------------------------------------------
module approx_mul_pipe #(
   parameter int N     = 8,
   parameter int L     = 6,
   parameter int T     = 7,
   parameter int ACC_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       x,
   input  logic [N-1:0]       y,
   input  logic               mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*N-1:0]     z,
   output logic [2*N-1:0]     err,
   input  logic               stat_clr,
   output logic [ACC_W-1:0]   err_sum,
   output logic [ACC_W-1:0]   txn_cnt
);

   localparam int PW = 2 * N;
   // Wide enough to hold err_sum + err without wrapping, whichever is wider.
   localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
   localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

   // The whole pipeline moves as one unit; bubbles shift like beats.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---------------------------------------------------------------- stage 1
   logic         s1_valid;
   logic [N-1:0] s1_x;
   logic [N-1:0] s1_y;
   logic         s1_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset too; it is cheap here and makes
         // z/err read 0 after reset instead of carrying stale operand data.
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mode  <= 1'b0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_x     <= x;
         s1_y     <= y;
         s1_mode  <= mode;
      end
   end

   // -------------------------------------------- partial products (comb)
   logic [PW-1:0] high_c;
   logic [PW-1:0] kept_c;
   logic [PW-1:0] drop_c;
   logic [PW-1:0] pp;

   always_comb begin
      high_c = ({{N{1'b0}}, s1_y} * {{(N + L){1'b0}}, s1_x[N-1:L]}) << L;
      kept_c = '0;
      drop_c = '0;
      pp     = '0;
      // NOTE: blocking assignments here are intentional: the loop accumulates
      // into kept_c/drop_c, each iteration reading the previous iteration's sum.
      for (int i = 0; i < L; i++) begin
         for (int j = 0; j < N; j++) begin
            pp = {{(PW - 1){1'b0}}, s1_x[i] & s1_y[j]} << (i + j);
            if (i + j >= T) kept_c = kept_c + pp;
            else            drop_c = drop_c + pp;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic          s2_valid;
   logic          s2_mode;
   logic [PW-1:0] s2_high;
   logic [PW-1:0] s2_kept;
   logic [PW-1:0] s2_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_mode  <= 1'b0;
         s2_high  <= '0;
         s2_kept  <= '0;
         s2_drop  <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         s2_high  <= high_c;
         s2_kept  <= kept_c;
         s2_drop  <= drop_c;
      end
   end

   // ---------------------------------------------------------------- stage 3
   // approx = high + kept, exact = approx + drop, so err is exactly drop.
   logic s3_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         s3_mode   <= 1'b0;
         z         <= '0;
         err       <= '0;
      end else if (advance) begin
         out_valid <= s2_valid;
         s3_mode   <= s2_mode;
         z         <= s2_mode ? (s2_high + s2_kept) : (s2_high + s2_kept + s2_drop);
         err       <= s2_drop;
      end
   end

   // ------------------------------------------------------------- statistics
   logic          count_en;
   logic [SW-1:0] sum_ext;

   assign count_en = out_valid && out_ready && s3_mode;
   assign sum_ext  = SW'(err_sum) + SW'(err);

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         err_sum <= '0;
         txn_cnt <= '0;
      end else if (count_en) begin
         err_sum <= (sum_ext > ACC_MAX) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
         txn_cnt <= (txn_cnt == {ACC_W{1'b1}}) ? txn_cnt : txn_cnt + ACC_W'(1);
      end
   end

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 8x8 l=6 truncated-row unsigned multipliers.
- Computes an exact product and a row/column-truncated approximate product for each operand pair, and returns the one selected per transaction.
- Reports the per-transaction error and keeps running error statistics in hardware, so PAM error characterisation needs no offline simulation.
- Sits between an operand source and a result sink, with a valid/ready handshake on both sides.

Parameters:
- N, 8: operand width (unsigned), N >= 4.
- L, 6: number of low multiplier rows (x[L-1:0]) that are approximated; 1 <= L <= N-1.
- T, 7: truncation column; in the approximated rows, bits with column i+j < T are dropped; 0 <= T <= 2N-2.
- ACC_W, 32: width of the error accumulator and the transaction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands.
- x  in  N  multiplier.
- y  in  N  multiplicand.
- mode  in  1  0 = exact result, 1 = approximate result.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- z  out  2N  selected product.
- err  out  2N  exact minus approximate for this transaction.
- stat_clr  in  1  clear the statistics.
- err_sum  out  ACC_W  saturating sum of err over mode=1 transactions.
- txn_cnt  out  ACC_W  saturating count of mode=1 transactions.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, z=0, err=0, err_sum=0, txn_cnt=0, all internal stage valids=0. in_ready=1 from the first cycle after reset.
- Arithmetic:
  - exact = x*y, 2N bits.
  - approx = (y * x[N-1:L]) << L, plus the sum over i<L and 0<=j<N with i+j>=T of x[i]&y[j] << (i+j).
  - Consequently approx <= exact always, err = exact - approx >= 0, and err < 2^T * L.
- Output select: z = mode ? approx : exact. err is reported for both modes.
- Pipeline: three register stages.
  - S1 registers x, y, mode.
  - S2 holds the exact high-row product and two partial sums, one for the kept low-row bits and one for the dropped low-row bits.
  - S3 holds z and err.
- Advance rule: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=1, every stage shifts one step, bubbles included; a beat enters S1 iff in_valid && in_ready.
  - When advance=0, all stages hold, and z and err stay stable while out_valid=1.
- Latency: with out_ready held at 1, an operand accepted in cycle k gives out_valid=1 in cycle k+3. Throughput is one result per cycle.
- Bubbles are not collapsed: a bubble in S2 or S3 is shifted through like a beat. This is decided behaviour.
- Statistics update on the output handshake (out_valid && out_ready) with mode=1 for that result:
  - err_sum += err, saturating at 2^ACC_W-1.
  - txn_cnt += 1, saturating at 2^ACC_W-1.
  - Results with mode=0 do not change the statistics.
- stat_clr zeroes err_sum and txn_cnt on the next edge. If stat_clr coincides with a handshake, clear wins and that transaction is not counted. stat_clr does not affect the pipeline.
- rst mid-operation discards all in-flight beats, with no output for them, and zeroes the statistics.
- Backpressure must never drop or duplicate a beat, and must never reorder results.

Test Plan:
- N=8, L=6, T=7, mode=1, x=255, y=255 -> z=64320, err=705, err_sum=705, txn_cnt=1, 3 cycles after acceptance.
- mode=0, x=255, y=255 -> z=65025, err=705; err_sum and txn_cnt unchanged.
- mode=1, x=3, y=5 -> z=0, err=15. mode=1, x=192, y=100 -> z=19200, err=0.
- Back-to-back stream of 20 random beats with out_ready toggled pseudo-randomly -> in-order results, each matching the reference model, and z/err stable whenever out_valid=1 and out_ready=0.
- ACC_W=8, repeated mode=1 x=255, y=255 -> err_sum sticks at 255 and txn_cnt saturates at 255. stat_clr asserted together with a handshake -> both statistics read 0 next cycle.
- rst asserted with 3 beats in flight -> out_valid=0 the next cycle, no stale results afterwards, statistics read 0.
